// File: rtl/enc_4_2_queued.sv
// Clocked 4-to-2 request encoder with pending capture register and valid/ready output stage.
// Optional rotating priority when ENC_4_2_ROUND_ROBIN_EN is defined; fixed priority otherwise.
module enc_4_2_queued #(
    parameter int unsigned PRIO_HIGH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic       EN,
    output logic [1:0] OUT,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam logic [IW-1:0] TOP_IDX = (PRIO_HIGH != 0) ? IW'(N - 1) : IW'(0);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  load_mask;
    logic [IW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] start;
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    logic          found;
    logic          load;

`ifdef ENC_4_2_ROUND_ROBIN_EN
    // ptr_q holds the index where the next search begins
    logic [IW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = TOP_IDX;
`endif

    // Priority search over pending, walking away from start in the PRIO_HIGH direction
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (PRIO_HIGH != 0) ? (start - IW'(i)) : (start + IW'(i));
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state and output stage logic
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        load      = ((state_q == EMPTY) || out_ready) && found;
        load_mask = load ? (N'(1) << sel) : '0;
        pending_d = (pending_q & ~load_mask) | (EN ? a : '0);
`ifdef ENC_4_2_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (load) begin
            out_d   = sel;
            state_d = HOLD;
`ifdef ENC_4_2_ROUND_ROBIN_EN
            ptr_d   = (PRIO_HIGH != 0) ? (sel - IW'(1)) : (sel + IW'(1));
`endif
        end else if ((state_q == HOLD) && out_ready) begin
            state_d = EMPTY;
        end
        out_valid_d = (state_d == HOLD);
        busy_d      = (|pending_d) | out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ENC_4_2_ROUND_ROBIN_EN
            ptr_q       <= TOP_IDX;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ENC_4_2_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign OUT       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_enc_4_2_queued.sv
// Bench for enc_4_2_queued: two instances (PRIO_HIGH=1 and 0) on shared stimulus,
// checked every cycle against a request-set model plus directed constant checks.
module tb_enc_4_2_queued;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic       en;
    logic       rdy;
    logic [1:0] out_h, out_l;
    logic       v_h, v_l, b_h, b_l;

    int ncmp;
    int nfail;

    // Model state, index 0 = PRIO_HIGH=1 instance, index 1 = PRIO_HIGH=0 instance
    logic [3:0] m_pend  [2];
    logic       m_valid [2];
    logic [1:0] m_out   [2];
    logic [1:0] m_ptr   [2];

    enc_4_2_queued #(.PRIO_HIGH(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .a(a), .EN(en),
        .OUT(out_h), .out_valid(v_h), .out_ready(rdy), .busy(b_h)
    );

    enc_4_2_queued #(.PRIO_HIGH(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .a(a), .EN(en),
        .OUT(out_l), .out_valid(v_l), .out_ready(rdy), .busy(b_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First set request met when walking from start toward lower (hi) or higher indices
    function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] start, input bit hi);
        int pos;
        for (int k = 0; k < 4; k++) begin
            pos = hi ? (int'(start) - k + 4) % 4 : (int'(start) + k) % 4;
            if (p[pos]) return 2'(pos);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]  = 4'h0;
            m_valid[d] = 1'b0;
            m_out[d]   = 2'd0;
            m_ptr[d]   = (d == 0) ? 2'd3 : 2'd0;
        end
    endtask

    task automatic model_step(input int d);
        bit         hi;
        logic [1:0] s;
        logic [1:0] w;
        logic [3:0] nxt;
        hi  = (d == 0);
`ifdef ENC_4_2_ROUND_ROBIN_EN
        s   = m_ptr[d];
`else
        s   = hi ? 2'd3 : 2'd0;
`endif
        nxt = m_pend[d];
        if ((!m_valid[d] || rdy) && (m_pend[d] != 4'h0)) begin
            w          = pick(m_pend[d], s, hi);
            nxt[w]     = 1'b0;
            m_out[d]   = w;
            m_valid[d] = 1'b1;
            m_ptr[d]   = hi ? w - 2'd1 : w + 2'd1;
        end else if (m_valid[d] && rdy) begin
            m_valid[d] = 1'b0;
        end
        m_pend[d] = nxt | (en ? a : 4'h0);
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_hi_out"},   {2'b00, out_h}, {2'b00, m_out[0]});
        chk({ph, "_hi_valid"}, {3'b000, v_h},  {3'b000, m_valid[0]});
        chk({ph, "_hi_busy"},  {3'b000, b_h},  {3'b000, (|m_pend[0]) | m_valid[0]});
        chk({ph, "_lo_out"},   {2'b00, out_l}, {2'b00, m_out[1]});
        chk({ph, "_lo_valid"}, {3'b000, v_l},  {3'b000, m_valid[1]});
        chk({ph, "_lo_busy"},  {3'b000, b_l},  {3'b000, (|m_pend[1]) | m_valid[1]});
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(ph);
        @(negedge clk);
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        rst_n = 1'b0;
        a     = 4'hF;
        en    = 1'b1;
        rdy   = 1'b1;
        model_reset();

        // Reset held with requests present: nothing captured
        repeat (3) @(negedge clk);
        check_all("rst");
        chk("rst_out_const", {2'b00, out_h}, 4'h0);
        chk("rst_busy_const", {3'b000, b_h}, 4'h0);

        // Release: capture on first edge, valid after second
        rst_n = 1'b1;
        tick("rel1");
        chk("rel_valid_edge1", {3'b000, v_h}, 4'h0);
        a = 4'h0;
        tick("rel2");
        chk("rel_valid_edge2", {3'b000, v_h}, 4'h1);
        chk("rel_hi_first", {2'b00, out_h}, 4'h3);
        chk("rel_lo_first", {2'b00, out_l}, 4'h0);
        repeat (4) tick("drain");

        // Single request: one issue of code 2, then idle
        a = 4'b0100;
        tick("single_cap");
        a = 4'h0;
        tick("single_iss");
        chk("single_out", {2'b00, out_h}, 4'h2);
        chk("single_valid", {3'b000, v_h}, 4'h1);
        tick("single_done");
        chk("single_valid_off", {3'b000, v_h}, 4'h0);
        chk("single_busy_off", {3'b000, b_h}, 4'h0);

        // Multi-hot: hi order 3,1,0 ; lo order 0,1,3
        a = 4'b1011;
        tick("multi_cap");
        a = 4'h0;
        tick("multi1");
        chk("multi1_hi", {2'b00, out_h}, 4'h3);
        chk("multi1_lo", {2'b00, out_l}, 4'h0);
        tick("multi2");
        chk("multi2_hi", {2'b00, out_h}, 4'h1);
        chk("multi2_lo", {2'b00, out_l}, 4'h1);
        tick("multi3");
        chk("multi3_hi", {2'b00, out_h}, 4'h0);
        chk("multi3_lo", {2'b00, out_l}, 4'h3);
        tick("multi_idle");

        // Backpressure: code held stable while out_ready low
        a   = 4'b0011;
        rdy = 1'b0;
        tick("bp_cap");
        a = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick("bp_hold");
            chk("bp_hold_hi", {2'b00, out_h}, 4'h1);
            chk("bp_hold_valid", {3'b000, v_h}, 4'h1);
        end
        rdy = 1'b1;
        tick("bp_rel");
        chk("bp_rel_hi", {2'b00, out_h}, 4'h0);
        tick("bp_end");
        chk("bp_end_valid", {3'b000, v_h}, 4'h0);

        // EN low blocks capture
        en = 1'b0;
        a  = 4'hF;
        repeat (3) tick("en_off");
        chk("en_off_busy", {3'b000, b_h}, 4'h0);
        en = 1'b1;

        // Re-request of the held bit issues a second time
        a   = 4'b0010;
        rdy = 1'b0;
        tick("rereq_cap");
        a = 4'h0;
        tick("rereq_held");
        a = 4'b0010;
        tick("rereq_again");
        a   = 4'h0;
        rdy = 1'b1;
        tick("rereq_2nd");
        chk("rereq_2nd_out", {2'b00, out_h}, 4'h1);
        chk("rereq_2nd_valid", {3'b000, v_h}, 4'h1);
        tick("rereq_end");
        chk("rereq_end_valid", {3'b000, v_h}, 4'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a   = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'h0;
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        // Asynchronous reset mid-operation discards everything at once
        a   = 4'hF;
        en  = 1'b1;
        rdy = 1'b0;
        tick("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        a = 4'h0;
        rst_n = 1'b1;
        rdy = 1'b1;
        repeat (2) tick("post_rst");
        chk("post_rst_busy", {3'b000, b_h}, 4'h0);

        // Continuous 1001 requests: rotation alternates, fixed priority repeats 3
        a = 4'b1001;
        tick("rr_cap");
        for (int k = 0; k < 6; k++) begin
            tick("rr");
`ifdef ENC_4_2_ROUND_ROBIN_EN
            chk("rr_hi_seq", {2'b00, out_h}, (k % 2 == 0) ? 4'h3 : 4'h0);
`else
            chk("fixed_hi_seq", {2'b00, out_h}, 4'h3);
`endif
        end
        a = 4'h0;
        repeat (6) tick("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
